// File: rtl/counter_chip_checker.sv
// counter_chip_checker: exhaustive tester for 74161/74163-class presettable
// binary counters, generalised to WIDTH bits and sync/async clear.
//
// Parameters:
//   WIDTH    counter width (1..8)
//   SETTLE   Clk cycles per DUT clock phase (>=1)
//   SYNC_CLR 1 = synchronous clear (74163), 0 = asynchronous clear (74161)
//
// Ports:
//   Clk, Reset (async, active-low)
//   Run        start request, sampled while halted
//   DISP_RSLT  result acknowledge, sampled while done
//   Q_in       DUT Q outputs (Q_in[0] = QA)
//   RCO_in     DUT ripple carry out
//   CLR_n, LOAD_n, ENP, ENT, D, CCLK   DUT drives
//   Done       test complete
//   RSLT       1 = DUT passed
//   Err_cnt    saturating mismatch count
//
// Optional build macro CAPTURE_FAIL_EN adds Fail_vec, Fail_q and Fail_phase,
// which record the vector index, observed Q and phase (0 = low, 1 = high) of
// the first failing sample since the test started.
module counter_chip_checker #(
    parameter int WIDTH    = 4,
    parameter int SETTLE   = 2,
    parameter bit SYNC_CLR = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             DISP_RSLT,
    input  logic [WIDTH-1:0] Q_in,
    input  logic             RCO_in,
    output logic             CLR_n,
    output logic             LOAD_n,
    output logic             ENP,
    output logic             ENT,
    output logic [WIDTH-1:0] D,
    output logic             CCLK,
    output logic             Done,
    output logic             RSLT,
    output logic [15:0]      Err_cnt
`ifdef CAPTURE_FAIL_EN
    ,
    output logic [WIDTH+3:0] Fail_vec,
    output logic [WIDTH-1:0] Fail_q,
    output logic             Fail_phase
`endif
);

    localparam int IW = WIDTH + 4;
    // Phase counter spans the 2*SETTLE cycles of INIT.
    localparam int CW = $clog2(2 * SETTLE);

    typedef enum logic [2:0] {
        S_HALTED,
        S_INIT,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [WIDTH-1:0] mq, mq_nxt;
    logic [15:0]      err_nxt;
    logic             start;
    logic             last;

    logic [WIDTH-1:0] v_d;
    logic             v_clr, v_load, v_enp, v_ent;

    logic [WIDTH-1:0] mq_step;
    logic [WIDTH-1:0] exp_q;
    logic             exp_rco;
    logic             sample;
    logic             miss;

    assign v_d    = idx[WIDTH-1:0];
    assign v_clr  = idx[WIDTH];
    assign v_load = idx[WIDTH+1];
    assign v_enp  = idx[WIDTH+2];
    assign v_ent  = idx[WIDTH+3];

    assign start = (state == S_HALTED) && Run;
    assign last  = (cnt == CW'(SETTLE - 1));
    assign Done  = (state == S_DONE);

    // DUT drives: only INIT and the vector phases drive anything non-zero.
    always_comb begin
        CLR_n  = 1'b0;
        LOAD_n = 1'b0;
        ENP    = 1'b0;
        ENT    = 1'b0;
        D      = '0;
        CCLK   = 1'b0;
        case (state)
            S_INIT: begin
                LOAD_n = 1'b1;
                ENP    = 1'b1;
                ENT    = 1'b1;
                CCLK   = (cnt >= CW'(SETTLE));
            end
            S_LOW, S_HIGH: begin
                CLR_n  = v_clr;
                LOAD_n = v_load;
                ENP    = v_enp;
                ENT    = v_ent;
                D      = v_d;
                CCLK   = (state == S_HIGH);
            end
            default: ;
        endcase
    end

    // Reference counter behaviour for one rising CCLK edge.
    always_comb begin
        mq_step = mq;
        if (!v_clr)
            mq_step = '0;
        else if (!v_load)
            mq_step = v_d;
        else if (v_enp && v_ent)
            mq_step = mq + WIDTH'(1);
    end

    // The model is advanced as HIGH is entered, so every HIGH cycle already
    // sees the post-edge value. An async-clear part shows zero during LOW.
    always_comb begin
        exp_q = mq;
        if (state == S_LOW && !SYNC_CLR && !v_clr)
            exp_q = '0;
        exp_rco = v_ent & (&exp_q);
        sample  = (state == S_LOW || state == S_HIGH) && last;
        miss    = sample && ((Q_in != exp_q) || (RCO_in != exp_rco));
        err_nxt = Err_cnt;
        if (miss && Err_cnt != 16'hFFFF)
            err_nxt = Err_cnt + 16'd1;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        mq_nxt    = mq;
        case (state)
            S_HALTED: begin
                if (Run) begin
                    state_nxt = S_INIT;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    mq_nxt    = '0;
                end
            end
            S_INIT: begin
                if (cnt == CW'(2 * SETTLE - 1)) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_LOW: begin
                if (last) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                    mq_nxt    = mq_step;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_HIGH: begin
                if (last) begin
                    cnt_nxt = '0;
                    if (&idx) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_LOW;
                        idx_nxt   = idx + IW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE: begin
                if (DISP_RSLT)
                    state_nxt = S_HALTED;
            end
            default: state_nxt = S_HALTED;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_HALTED;
            cnt     <= '0;
            idx     <= '0;
            mq      <= '0;
            Err_cnt <= '0;
            RSLT    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            mq    <= mq_nxt;
            if (start) begin
                Err_cnt <= '0;
                RSLT    <= 1'b0;
            end else begin
                Err_cnt <= err_nxt;
                // err_nxt folds in the final HIGH sample taken this cycle.
                if (state == S_HIGH && state_nxt == S_DONE)
                    RSLT <= (err_nxt == 16'd0);
            end
        end
    end

`ifdef CAPTURE_FAIL_EN
    logic fail_seen;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fail_seen  <= 1'b0;
            Fail_vec   <= '0;
            Fail_q     <= '0;
            Fail_phase <= 1'b0;
        end else if (start) begin
            fail_seen  <= 1'b0;
            Fail_vec   <= '0;
            Fail_q     <= '0;
            Fail_phase <= 1'b0;
        end else if (miss && !fail_seen) begin
            fail_seen  <= 1'b1;
            Fail_vec   <= idx;
            Fail_q     <= Q_in;
            Fail_phase <= (state == S_HIGH);
        end
    end
`endif

endmodule

// File: tb/tb_counter_chip_checker.sv
// tb_counter_chip_checker: drives counter_chip_checker against a behavioural
// 74161/74163 part with optional injected faults.
module tb_counter_chip_checker;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Run = 1'b0;
    logic       DISP_RSLT = 1'b0;
    logic [3:0] Q_in;
    logic       RCO_in;
    logic       CLR_n, LOAD_n, ENP, ENT, CCLK, Done, RSLT;
    logic [3:0] D;
    logic [15:0] Err_cnt;
`ifdef CAPTURE_FAIL_EN
    logic [7:0] Fail_vec;
    logic [3:0] Fail_q;
    logic       Fail_phase;
`endif

    int checks = 0;
    int failures = 0;

    // Fault kinds: 0 good 74163, 1 good 74161 (async clear), 2 Q stuck-at-0,
    // 3 Q stuck-at-1, 4 RCO stuck high, 5 RCO stuck low.
    int fk = 0;
    int fb = 0;
    logic [3:0] cq = 4'h0;

    always #5 Clk = ~Clk;

    counter_chip_checker #(
        .WIDTH(4),
        .SETTLE(2),
        .SYNC_CLR(1'b1)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Run(Run),
        .DISP_RSLT(DISP_RSLT),
        .Q_in(Q_in),
        .RCO_in(RCO_in),
        .CLR_n(CLR_n),
        .LOAD_n(LOAD_n),
        .ENP(ENP),
        .ENT(ENT),
        .D(D),
        .CCLK(CCLK),
        .Done(Done),
        .RSLT(RSLT),
        .Err_cnt(Err_cnt)
`ifdef CAPTURE_FAIL_EN
        ,
        .Fail_vec(Fail_vec),
        .Fail_q(Fail_q),
        .Fail_phase(Fail_phase)
`endif
    );

    // Behavioural counter chip. Drives only change while CCLK is low, so a
    // falling CLR_n never coincides with a high CCLK.
    always @(posedge CCLK or negedge CLR_n) begin
        if (!CLR_n) begin
            if (fk == 1 || CCLK)
                cq <= 4'h0;
        end else if (!LOAD_n) begin
            cq <= D;
        end else if (ENP && ENT) begin
            cq <= cq + 4'h1;
        end
    end

    always_comb begin
        Q_in = cq;
        if (fk == 2)
            Q_in[fb[1:0]] = 1'b0;
        if (fk == 3)
            Q_in[fb[1:0]] = 1'b1;
        RCO_in = ENT && (cq == 4'hF);
        if (fk == 4)
            RCO_in = 1'b1;
        if (fk == 5)
            RCO_in = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Walks all 256 vectors with plain arithmetic: chip value c and ideal
    // 74163 value m, sampled before and after each rising edge.
    task automatic ref_run(input int kind, input int bitn, output int err,
                           output logic [7:0] fv, output logic [3:0] fq,
                           output logic fph);
        int c, m, d;
        bit clr, ld, en_p, en_t, seen, rco_o, rco_e;
        logic [3:0] qo;
        c = 0; m = 0; err = 0; fv = 0; fq = 0; fph = 0; seen = 0;
        for (int i = 0; i < 256; i++) begin
            d    = i % 16;
            clr  = ((i >> 4) & 1) != 0;
            ld   = ((i >> 5) & 1) != 0;
            en_p = ((i >> 6) & 1) != 0;
            en_t = ((i >> 7) & 1) != 0;
            for (int ph = 0; ph < 2; ph++) begin
                if (ph == 1) begin
                    c = !clr ? 0 : !ld ? d : (en_p && en_t) ? (c + 1) % 16 : c;
                    m = !clr ? 0 : !ld ? d : (en_p && en_t) ? (m + 1) % 16 : m;
                end else if (kind == 1 && !clr) begin
                    c = 0;
                end
                qo = 4'(c);
                if (kind == 2) qo[bitn] = 1'b0;
                if (kind == 3) qo[bitn] = 1'b1;
                rco_o = en_t && (c == 15);
                if (kind == 4) rco_o = 1'b1;
                if (kind == 5) rco_o = 1'b0;
                rco_e = en_t && (m == 15);
                if (qo != 4'(m) || rco_o != rco_e) begin
                    err++;
                    if (!seen) begin
                        seen = 1;
                        fv = 8'(i);
                        fq = qo;
                        fph = (ph == 1);
                    end
                end
            end
        end
    endtask

    task automatic run_chk(input int kind, input int bitn, input bit ack,
                           input string tag);
        int lat, rerr;
        logic [7:0] rfv;
        logic [3:0] rfq;
        logic rph;
        fk = kind;
        fb = bitn;
        ref_run(kind, bitn, rerr, rfv, rfq, rph);
        @(posedge Clk); #1 Run = 1'b1;
        @(posedge Clk); #1 Run = 1'b0;
        lat = 1;
        while (!Done && lat < 3000) begin
            @(posedge Clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 1029);
        chk({tag, "_err_cnt"}, Err_cnt, rerr);
        chk({tag, "_rslt"}, RSLT, rerr == 0);
`ifdef CAPTURE_FAIL_EN
        chk({tag, "_fail_vec"}, Fail_vec, rfv);
        chk({tag, "_fail_q"}, Fail_q, rfq);
        chk({tag, "_fail_phase"}, Fail_phase, rph);
`endif
        if (ack) begin
            DISP_RSLT = 1'b1;
            @(posedge Clk); #1 DISP_RSLT = 1'b0;
            chk({tag, "_done_clr"}, Done, 0);
            chk({tag, "_rslt_kept"}, RSLT, rerr == 0);
        end
    endtask

    typedef struct {
        int         kind;
        int         bitn;
        logic       rslt;
        logic [7:0] fv;
        logic [3:0] fq;
        logic       fph;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int hs_bad;
        tbl[0] = '{0, 0, 1'b1, 8'h00, 4'h0, 1'b0};
        tbl[1] = '{2, 2, 1'b0, 8'h14, 4'h0, 1'b1};
        tbl[2] = '{1, 0, 1'b0, 8'h20, 4'h0, 1'b0};
        tbl[3] = '{4, 0, 1'b0, 8'h00, 4'h0, 1'b0};

        repeat (3) @(posedge Clk);
        #1;
        chk("reset_outputs", {CLR_n, LOAD_n, ENP, ENT, D, CCLK, Done, RSLT,
                              Err_cnt}, 0);
`ifdef CAPTURE_FAIL_EN
        chk("reset_capture", {Fail_vec, Fail_q, Fail_phase}, 0);
`endif
        @(negedge Clk) Reset = 1'b1;

        for (int t = 0; t < 4; t++) begin
            run_chk(tbl[t].kind, tbl[t].bitn, 1'b1, $sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d_rslt_tbl", t), RSLT, tbl[t].rslt);
            if (!tbl[t].rslt)
                chk($sformatf("tbl%0d_err_nz", t), Err_cnt != 0, 1);
`ifdef CAPTURE_FAIL_EN
            chk($sformatf("tbl%0d_fvec_tbl", t), Fail_vec, tbl[t].fv);
            chk($sformatf("tbl%0d_fq_tbl", t), Fail_q, tbl[t].fq);
            chk($sformatf("tbl%0d_fph_tbl", t), Fail_phase, tbl[t].fph);
`endif
        end

        for (int r = 0; r < 4; r++)
            run_chk(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                    1'b1, $sformatf("rnd%0d", r));

        // Reset in the middle of a faulted run.
        fk = 2;
        fb = 2;
        @(posedge Clk); #1 Run = 1'b1;
        @(posedge Clk); #1 Run = 1'b0;
        repeat (499) @(posedge Clk);
        #1;
        chk("mid_err_nz", Err_cnt != 0, 1);
        #2 Reset = 1'b0;
        #1;
        chk("mid_reset_outputs", {CLR_n, LOAD_n, ENP, ENT, D, CCLK, Done,
                                  RSLT, Err_cnt}, 0);
`ifdef CAPTURE_FAIL_EN
        chk("mid_reset_capture", {Fail_vec, Fail_q, Fail_phase}, 0);
`endif
        @(negedge Clk) Reset = 1'b1;
        run_chk(0, 0, 1'b1, "after_rst");

        // Result handshake with a stray Run while Done is held.
        run_chk(3, 0, 1'b0, "hs");
        hs_bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 10) Run = 1'b1;
            if (k == 12) Run = 1'b0;
            @(posedge Clk); #1;
            chk("hs_done_held", Done, 1);
            if (CCLK || CLR_n || LOAD_n || ENP || ENT)
                hs_bad++;
        end
        chk("hs_no_drive", hs_bad, 0);
        DISP_RSLT = 1'b1;
        @(posedge Clk); #1 DISP_RSLT = 1'b0;
        chk("hs_done_low", Done, 0);
        chk("hs_rslt_kept", RSLT, 0);
        hs_bad = 0;
        repeat (10) begin
            @(posedge Clk); #1;
            if (CCLK || CLR_n || LOAD_n || Done)
                hs_bad++;
        end
        chk("hs_no_restart", hs_bad, 0);
        chk("hs_err_kept", Err_cnt != 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_chip_checker.md
Name: counter_chip_checker

Overview:
- Parametrised tester for synchronous presettable binary counter ICs (74161/74163 class), generalised to WIDTH Q bits and to synchronous or asynchronous clear.
- Steps an exhaustive control/data vector sequence into the DUT, runs an internal reference model, compares Q and RCO twice per vector, counts mismatches and reports pass/fail.
- Sits beside the other chip checkers under the top-level Run/Done/DISP_RSLT sequencer.

Parameters:
- WIDTH, 4, number of counter bits (Q/D width); 1..8.
- SETTLE, 2, Clk cycles per DUT clock phase (low and high); >=1.
- SYNC_CLR, 1, 1 = clear is synchronous (74163), 0 = clear is asynchronous (74161).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- Run  in  1  start request, sampled in HALTED
- DISP_RSLT  in  1  result acknowledge, sampled in DONE
- Q_in  in  WIDTH  DUT Q outputs, Q_in[0]=QA
- RCO_in  in  1  DUT ripple carry out
- CLR_n  out  1  DUT clear
- LOAD_n  out  1  DUT load
- ENP  out  1  DUT count enable P
- ENT  out  1  DUT count enable T
- D  out  WIDTH  DUT preset data
- CCLK  out  1  DUT clock
- Done  out  1  test complete
- RSLT  out  1  1 = pass
- Err_cnt  out  16  mismatch count, saturating

Behaviour:
- Reset low (async): state HALTED; every output 0; model Q=0; Err_cnt=0; vector index=0.
- States: HALTED -> INIT -> LOW -> HIGH -> (LOW | DONE) -> HALTED.
- HALTED: all DUT drives 0. Run=1 -> INIT, clears Err_cnt, index=0. RSLT holds its previous value until INIT.
- INIT: CLR_n=0, LOAD_n=ENP=ENT=1, D=0; CCLK low SETTLE cycles, then high SETTLE cycles; no compare; model Q=0; -> LOW.
- Vector mapping, index i of WIDTH+4 bits: D=i[WIDTH-1:0], CLR_n=i[WIDTH], LOAD_n=i[WIDTH+1], ENP=i[WIDTH+2], ENT=i[WIDTH+3]. Drives are stable for the whole vector.
- LOW: CCLK=0 for SETTLE cycles. Compare on the last cycle:
  - expected Q = 0 if (SYNC_CLR=0 and CLR_n=0), else model Q;
  - expected RCO = ENT & (expected Q == all ones).
- HIGH: CCLK=1 for SETTLE cycles. On the first cycle the model updates, in this priority:
  - !CLR_n -> 0;
  - else !LOAD_n -> D;
  - else ENP&ENT -> Q+1 mod 2^WIDTH;
  - else hold.
- HIGH compare: on the last cycle, same RCO rule against the updated model.
- After HIGH: if i is all ones -> DONE, else i+1 -> LOW.
- Each failing sample point (Q or RCO mismatch) adds 1 to Err_cnt; Err_cnt saturates at 16'hFFFF.
- DONE:
  - Done=1, all DUT drives 0;
  - RSLT = (Err_cnt==0), registered on entry;
  - DISP_RSLT=1 -> HALTED, Done=0 next cycle;
  - Run ignored.
- Run while not HALTED: ignored.
- Latency: Done rises 1 + 2*SETTLE*(1+2^(WIDTH+4)) Clk cycles after Run is sampled. WIDTH=4, SETTLE=2 gives 1029.
- Reset mid-test: immediate idle; a new Run restarts from INIT with no residue.

Optional Feature:
- Macro: CAPTURE_FAIL_EN.
- Defined: adds outputs Fail_vec (WIDTH+4), Fail_q (WIDTH), Fail_phase (1; 0=LOW, 1=HIGH). These latch the index, observed Q_in and phase of the first failing sample after INIT; they hold until the next INIT and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Behavioural 74163 model, WIDTH=4, SYNC_CLR=1, SETTLE=2, Run pulse -> Done at cycle 1029, RSLT=1, Err_cnt=0.
- Same, Q[2] stuck-at-0 -> RSLT=0, Err_cnt>0; with CAPTURE_FAIL_EN: Fail_vec=8'h14, Fail_q=4'h0, Fail_phase=1.
- 74161 model against a SYNC_CLR=1 checker -> RSLT=0; with CAPTURE_FAIL_EN: Fail_vec=8'h20, Fail_q=4'h0, Fail_phase=0. Same model with SYNC_CLR=0 -> RSLT=1.
- RCO stuck-high on a good counter -> first fail at vector 8'h00, LOW phase; Err_cnt >= 1.
- Reset low at cycle 500 -> all outputs 0 the same cycle. Release, then Run -> full pass in 1029 cycles, Err_cnt=0.
- Handshake: hold DISP_RSLT=0 for 50 cycles after Done, pulse Run meanwhile -> Done stays 1, no restart. DISP_RSLT=1 -> HALTED next cycle, RSLT retained.
